// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: FSM states, error codes and
// the bit positions of the fields inside the frame header byte.
package loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_CHK,
        ST_DONE,
        ST_ERR
    } loaderState_t;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_CSUM = 2'b01;
    localparam logic [1:0] ERR_TMO  = 2'b10;

    // Header byte: [7:4] start address, [3:0] word count minus one
    localparam int HDR_ADDR_LSB = 4;
    localparam int HDR_LEN_LSB  = 0;
    localparam int HDR_LEN_W    = 4;

    // True in the states where the loader is consuming stream bytes
    function automatic logic isLoading(input loaderState_t s);
        return (s == ST_HDR) || (s == ST_DATA) || (s == ST_CHK);
    endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte stream input plus the RAM programming port of the loader.
// The slave modport is the loader's view; master is the stream source/RAM side.
interface program_loader_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;
    logic              prog_mode;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_data;

    modport master (
        output s_valid, s_data,
        input  s_ready, prog_mode, prog_we, prog_addr, prog_data
    );

    modport slave (
        input  s_valid, s_data,
        output s_ready, prog_mode, prog_we, prog_addr, prog_data
    );
endinterface

// File: rtl/program_loader_timeout.sv
// Idle-cycle watchdog: counts enabled cycles since the last clear and flags
// the cycle in which the count would reach TIMEOUT. TIMEOUT = 0 disables it.
module loader_timeout #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Clear has priority so a transfer always restarts the idle window
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + CW'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // A clear in the same cycle (a transfer) wins over expiry
    assign expired = (TIMEOUT != 0) && enable && !clear
                     && (int'(count_q) == TIMEOUT - 1);

endmodule

// File: rtl/program_loader.sv
// Framed boot loader: receives header/data/checksum bytes, writes the data
// into program RAM and releases the CPU only after a good checksum.
module program_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    program_loader_if.slave     bus,
    output logic                cpu_run,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [1:0]          err_code
);
    loaderState_t          state_q, state_d;
    logic [ADDR_W-1:0]     curAddr_q, curAddr_d;
    logic [HDR_LEN_W-1:0]  remaining_q, remaining_d;
    logic [DATA_W-1:0]     sum_q, sum_d;
    logic                  progWe_q, progWe_d;
    logic [ADDR_W-1:0]     progAddr_q, progAddr_d;
    logic [DATA_W-1:0]     progData_q, progData_d;
    logic [1:0]            errCode_q, errCode_d;

    logic loading;
    logic transfer;
    logic tmoExpired;

    assign loading  = isLoading(state_q);
    assign transfer = bus.s_valid && loading;

    loader_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (transfer || !loading),
        .enable  (loading),
        .expired (tmoExpired)
    );

    // Frame parser: walks header, data and checksum, schedules RAM writes
    always_comb begin
        state_d     = state_q;
        curAddr_d   = curAddr_q;
        remaining_d = remaining_q;
        sum_d       = sum_q;
        progWe_d    = 1'b0;
        progAddr_d  = progAddr_q;
        progData_d  = progData_q;
        errCode_d   = errCode_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                if (transfer) begin
                    curAddr_d   = bus.s_data[HDR_ADDR_LSB +: ADDR_W];
                    remaining_d = bus.s_data[HDR_LEN_LSB +: HDR_LEN_W];
                    sum_d       = '0;
                    state_d     = ST_DATA;
                end
            end
            ST_DATA: begin
                if (transfer) begin
                    progWe_d   = 1'b1;
                    progAddr_d = curAddr_q;
                    progData_d = bus.s_data;
                    sum_d      = sum_q + bus.s_data;
                    curAddr_d  = curAddr_q + ADDR_W'(1);
                    if (remaining_q == '0) begin
                        state_d = ST_CHK;
                    end else begin
                        remaining_d = remaining_q - HDR_LEN_W'(1);
                    end
                end
            end
            ST_CHK: begin
                if (transfer) begin
                    if (bus.s_data == sum_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d   = ST_ERR;
                        errCode_d = ERR_CSUM;
                    end
                end
            end
            ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d   = ST_HDR;
                    errCode_d = ERR_NONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (tmoExpired) begin
            state_d   = ST_ERR;
            errCode_d = ERR_TMO;
        end
    end

    // State, datapath and registered RAM port
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            curAddr_q   <= '0;
            remaining_q <= '0;
            sum_q       <= '0;
            progWe_q    <= 1'b0;
            progAddr_q  <= '0;
            progData_q  <= '0;
            errCode_q   <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            curAddr_q   <= curAddr_d;
            remaining_q <= remaining_d;
            sum_q       <= sum_d;
            progWe_q    <= progWe_d;
            progAddr_q  <= progAddr_d;
            progData_q  <= progData_d;
            errCode_q   <= errCode_d;
        end
    end

    assign bus.s_ready   = loading;
    assign bus.prog_mode = loading;
    assign bus.prog_we   = progWe_q;
    assign bus.prog_addr = progAddr_q;
    assign bus.prog_data = progData_q;
    assign busy          = loading;
    assign done          = (state_q == ST_DONE);
    assign cpu_run       = (state_q == ST_DONE);
    assign error         = (state_q == ST_ERR);
    assign err_code      = errCode_q;

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Byte-stream boot loader that sits directly upstream of the 16x8 program RAM and the CPU core.
- Accepts a framed program image over a valid/ready byte interface and drives the RAM programming port (mode, address, data) while holding the CPU in reset.
- On a good checksum, releases the CPU to run; on a bad checksum or a stalled stream, flags an error.
- Replaces hand-poked input_mode/input_address/input_program sequences in benches and on hardware.

Parameters:
- ADDR_W, 4: RAM address width; images wrap modulo 2^ADDR_W.
- DATA_W, 8: RAM word and stream byte width.
- TIMEOUT, 255: maximum idle cycles allowed between accepted bytes while loading; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high; one clock; clears all state
- start  in  1  one-cycle pulse that begins a load session
- s_valid  in  1  stream byte valid
- s_data  in  DATA_W  stream byte
- s_ready  out  1  loader accepts s_data this cycle (transfer = s_valid & s_ready)
- prog_mode  out  1  RAM programming mode, drives RAM input_mode
- prog_we  out  1  one-cycle write strobe to RAM
- prog_addr  out  ADDR_W  RAM write address, drives input_address
- prog_data  out  DATA_W  RAM write data, drives input_program
- cpu_run  out  1  CPU release; drives the CPU active-low reset (0 = CPU held in reset)
- busy  out  1  load session in progress
- done  out  1  image loaded with a good checksum
- error  out  1  load failed
- err_code  out  2  01 = checksum mismatch, 10 = timeout; 00 otherwise

Behaviour:
- Reset values: state IDLE. s_ready, prog_mode, prog_we, cpu_run, busy, done, error = 0. prog_addr = 0, prog_data = 0, err_code = 00.
- Frame format: header byte, then N data bytes, then a checksum byte.
  - Header [7:4] = start address; header [3:0] = N-1, so N is 1..16.
  - Checksum = sum of the N data bytes mod 256. The header is not included.
- States: IDLE, HDR, DATA, CHK, DONE, ERR.
- IDLE:
  - s_ready = 0.
  - start moves to HDR.
- HDR:
  - s_ready = 1, prog_mode = 1, busy = 1.
  - On transfer: latch addr = hdr[7:4], remaining = hdr[3:0], clear the running sum, go to DATA.
- DATA:
  - s_ready = 1, prog_mode = 1, busy = 1.
  - On transfer, in the next cycle: prog_we = 1, prog_addr = current addr, prog_data = byte. The sum adds the byte.
  - After each write, addr increments mod 16 (0xF wraps to 0x0).
  - When remaining = 0 on a transfer, go to CHK; otherwise decrement remaining.
  - prog_addr and prog_data hold their last written values between writes.
  - Write latency: exactly 1 cycle from transfer to prog_we.
- CHK:
  - s_ready = 1, prog_mode = 1, busy = 1.
  - On transfer: if byte == sum, go to DONE; otherwise go to ERR with err_code = 01.
- DONE:
  - prog_mode = 0, done = 1, cpu_run = 1.
  - Stays in DONE until reset or start.
- ERR:
  - error = 1, prog_mode = 0, cpu_run = 0.
  - Stays in ERR until reset or start.
- cpu_run is 0 in every state except DONE. The final prog_we (last data byte) completes before the CHK transfer, so RAM is fully written before cpu_run can rise.
- start handling:
  - In DONE or ERR: go to HDR the next cycle. done, error and err_code clear; cpu_run drops to 0 in that same cycle.
  - In HDR, DATA or CHK: ignored.
- Timeout:
  - In HDR, DATA or CHK, an idle counter increments each cycle without a transfer and clears on every transfer.
  - When the counter reaches TIMEOUT (and TIMEOUT ≠ 0), go to ERR with err_code = 10.
  - If a transfer occurs in the same cycle the counter reaches TIMEOUT, the transfer wins.
- s_valid while s_ready = 0: the byte is not consumed; there are no side effects.
- Reset mid-load: on the next edge, return to IDLE with reset values; partial RAM contents are left as-is.
- prog_we is never asserted outside the DATA-induced cycle.

Decomposition:
- Shared package loader_pkg holds:
  - the state enum (IDLE, HDR, DATA, CHK, DONE, ERR);
  - err_code constants ERR_NONE = 00, ERR_CSUM = 01, ERR_TMO = 10;
  - header field positions.
- One natural sub-module, loader_timeout: a parameterised idle counter with clear/enable inputs and an expired output.
- The FSM, address/count registers and checksum accumulator live in program_loader.

Test Plan:
- Nominal load:
  - Stimulus: reset, start, then stream 0x04, 0x79, 0x30, 0x7A, 0x10, 0x40, 0x73 with s_valid held high.
  - Response: five prog_we pulses at addresses 0–4 with those data bytes; done = 1, cpu_run = 1, err_code = 00; no prog_we after CHK.
- Address wrap:
  - Stimulus: header 0xE2, then 0x08, 0x0B, 0x01, checksum 0x14.
  - Response: writes at addresses E, F, 0; done = 1.
- Checksum fail:
  - Stimulus: the nominal frame with checksum 0x72.
  - Response: all five writes still occur; error = 1, err_code = 01, cpu_run = 0, s_ready = 0.
- Timeout and restart:
  - Stimulus: TIMEOUT = 8; send header 0x01 and one data byte, then idle.
  - Response: after 8 idle cycles, error = 1 and err_code = 10. A subsequent start returns to HDR with error cleared, and a good frame then ends in DONE.
- Backpressure and gaps:
  - Stimulus: random s_valid gaps (each shorter than TIMEOUT) during the nominal frame.
  - Response: identical write sequence and done; s_ready = 0 in IDLE, so a byte presented before start is not consumed.
- Reset mid-DATA:
  - Stimulus: assert reset after the second data write.
  - Response: next cycle state = IDLE, prog_mode = 0, prog_addr = 0, busy = 0, cpu_run = 0. start is ignored while in DATA (it does not restart the frame).
